// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and helpers for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: first-word-fall-through prefetch buffer of {pc, instr} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, do_push, do_pop;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(DEPTH);
    assign count = cnt_q;
    assign head  = mem_q[rd_q];

    // pointer and occupancy next state; a flush discards everything, including a same-cycle push
    always_comb begin
        do_push = push && !flush && !full;
        do_pop  = pop && !flush && !empty;
        rd_d    = flush ? '0 : rd_q + AW'(do_pop);
        wr_d    = flush ? '0 : wr_q + AW'(do_push);
        cnt_d   = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // entry storage; contents are only observed through a valid head, so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !flush && full));

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding word fetcher feeding the core through a prefetch FIFO
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic          stale_q, stale_d;
    logic          push, pop, empty;
    logic [CW-1:0] count;
    fetch_entry_t  head, push_entry;

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = !empty;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign pop         = instr_valid && instr_ready;
    assign push_entry  = '{pc: addr_q, instr: imem_rdata};

    // fetch sequencing: issue only with a free FIFO slot, hold the request until granted, redirect overrides
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        stale_d    = stale_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redirect_valid && count < CW'(DEPTH)) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    state_d    = WAIT;
                    req_d      = 1'b0;
                    fetch_pc_d = stale_q ? fetch_pc_q : fetch_pc_q + 32'd4;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                    push    = !stale_q && !redirect_valid;
                    stale_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            if (state_q == REQ || (state_q == WAIT && !imem_rvalid)) stale_d = 1'b1;
        end
    end

    // fetch state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            stale_q    <= stale_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .count     (count)
    );

    a_req_hold: assert property (@(posedge clk) disable iff (rst)
        imem_req && !imem_gnt |=> imem_req && $stable(imem_addr));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized memory/core stimulus with a queue scoreboard of the expected instruction stream
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          BOUND    = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t push_pend[$];
    fetch_entry_t popped[$];
    logic [31:0]  fresh_gnts[$];
    logic         flush_pend = 1'b0;

    int          epoch = 0;
    logic [31:0] next_pc = RESET_PC;
    logic        pending = 1'b0;
    int          delay = 0;
    logic [31:0] pend_addr = '0;
    int          pend_epoch = 0;
    logic        req_seen = 1'b0;
    int          req_epoch = 0;
    logic [31:0] req_addr = '0;

    int          p_ready = 100;
    int          p_gnt = 100;
    int          p_redir = 0;
    int          max_dly = 1;
    logic        nop_data = 1'b1;
    logic        force_redir = 1'b0;
    logic        force_ready = 1'b0;
    logic [31:0] force_pc = '0;

    instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return nop_data ? NOP_INSTR : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock of stimulus: commit last cycle's model events, then play memory and core for this cycle
    task automatic step();
        logic gnt_now;
        logic resp_now;
        @(posedge clk);
        #1;
        if (flush_pend) exp_q.delete();
        while (push_pend.size() > 0) begin
            exp_q.push_back(push_pend.pop_front());
            check("fifo_credit", 32'(exp_q.size() <= DEPTH), 32'd1);
        end
        flush_pend     = 1'b0;
        gnt_now        = 1'b0;
        resp_now       = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        instr_ready    = force_ready || ($urandom_range(99) < p_ready);
        force_ready    = 1'b0;
        if (pending) begin
            check("single_outstanding", 32'(imem_req), 32'd0);
        end else if (imem_req && !req_seen) begin
            req_seen  = 1'b1;
            req_epoch = epoch;
            req_addr  = imem_addr;
            check("fetch_addr", imem_addr, next_pc);
            next_pc = next_pc + 32'd4;
        end else if (imem_req) begin
            check("addr_stable", imem_addr, req_addr);
        end
        if (pending) begin
            delay = delay - 1;
            if (delay == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pending     = 1'b0;
                resp_now    = 1'b1;
            end
        end else if (imem_req && $urandom_range(99) < p_gnt) begin
            imem_gnt   = 1'b1;
            gnt_now    = 1'b1;
            pending    = 1'b1;
            delay      = $urandom_range(max_dly, 1);
            pend_addr  = req_addr;
            pend_epoch = req_epoch;
            req_seen   = 1'b0;
        end
        if (force_redir || $urandom_range(999) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_redir ? force_pc : $urandom();
            force_redir    = 1'b0;
            epoch++;
            next_pc    = {redirect_pc[31:2], 2'b00};
            flush_pend = 1'b1;
        end
        if (gnt_now && pend_epoch == epoch) fresh_gnts.push_back(pend_addr);
        if (resp_now && pend_epoch == epoch) push_pend.push_back(fetch_entry_t'{pc: pend_addr, instr: imem_rdata});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        instr_ready    = 1'b0;
        pending        = 1'b0;
        req_seen       = 1'b0;
        flush_pend     = 1'b0;
        force_redir    = 1'b0;
        force_ready    = 1'b0;
        epoch++;
        next_pc = RESET_PC;
        exp_q.delete();
        push_pend.delete();
        popped.delete();
        fresh_gnts.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_no_req", 32'(imem_req), 32'd0);
        end
        rst = 1'b0;
    endtask

    // monitor: compare the presented head against the scoreboard and retire it when the core takes it
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() == 0) begin
                check("instr_valid_empty", 32'(instr_valid), 32'd0);
            end else begin
                check("instr_valid", 32'(instr_valid), 32'd1);
                check("instr_pc", instr_pc, exp_q[0].pc);
                check("instr", instr, exp_q[0].instr);
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                popped.push_back(fetch_entry_t'{pc: instr_pc, instr: instr});
                if (exp_q.size() > 0) exp_q.delete(0);
            end
        end
    end

    initial begin
        int n;
        int idx;
        int pcnt;

        do_reset();
        repeat (15) step();
        check("t1_grant_rate", 32'(fresh_gnts.size()), 32'd5);
        for (int i = 0; i < 3; i++) begin
            check("t1_imem_addr", i < fresh_gnts.size() ? fresh_gnts[i] : 32'hDEAD_BEEF, 32'(i * 4));
            check("t1_instr_pc", i < popped.size() ? popped[i].pc : 32'hDEAD_BEEF, 32'(i * 4));
            check("t1_instr", i < popped.size() ? popped[i].instr : 32'hDEAD_BEEF, NOP_INSTR);
        end

        nop_data = 1'b0;
        p_ready  = 0;
        do_reset();
        repeat (30) step();
        check("t2_grants", 32'(fresh_gnts.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("t2_addr", i < fresh_gnts.size() ? fresh_gnts[i] : 32'hDEAD_BEEF, 32'(i * 4));
        check("t2_req_idle", 32'(imem_req), 32'd0);
        p_ready = 100;
        n = 0;
        while (popped.size() == 0 && n < BOUND) begin step(); n++; end
        check("t2_pop_wait", 32'(n < BOUND), 32'd1);
        check("t2_first_pop", popped.size() > 0 ? popped[0].pc : 32'hDEAD_BEEF, 32'h0);
        n = 0;
        while (fresh_gnts.size() < 5 && n < BOUND) begin step(); n++; end
        check("t2_next_addr", fresh_gnts.size() > 4 ? fresh_gnts[4] : 32'hDEAD_BEEF, 32'h10);

        max_dly = 3;
        do_reset();
        n = 0;
        while (!(pending && pend_addr == 32'h4) && n < BOUND) begin step(); n++; end
        check("t3_wait", 32'(n < BOUND), 32'd1);
        popped.delete();
        idx         = fresh_gnts.size();
        force_redir = 1'b1;
        force_pc    = 32'h0000_8003;
        n = 0;
        while (popped.size() == 0 && n < BOUND) begin step(); n++; end
        check("t3_next_addr", fresh_gnts.size() > idx ? fresh_gnts[idx] : 32'hDEAD_BEEF, 32'h8000);
        check("t3_first_pc", popped.size() > 0 ? popped[0].pc : 32'hDEAD_BEEF, 32'h8000);
        check("t3_first_instr", popped.size() > 0 ? popped[0].instr : 32'hDEAD_BEEF, mem_word(32'h8000));

        p_ready = 0;
        max_dly = 2;
        do_reset();
        n = 0;
        while (!(exp_q.size() >= 1 && pending && delay == 1) && n < BOUND) begin step(); n++; end
        check("t4_wait", 32'(n < BOUND), 32'd1);
        pcnt        = popped.size();
        force_redir = 1'b1;
        force_pc    = 32'h0000_0100;
        force_ready = 1'b1;
        step();
        check("t4_coincide", 32'(imem_rvalid && instr_valid && instr_ready && redirect_valid), 32'd1);
        step();
        check("t4_flushed", 32'(instr_valid), 32'd0);
        check("t4_no_pop", 32'(popped.size()), 32'(pcnt));

        p_ready = 100;
        p_gnt   = 70;
        idx         = fresh_gnts.size();
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFFC;
        n = 0;
        while (fresh_gnts.size() < idx + 2 && n < BOUND) begin step(); n++; end
        check("t5_wrap_first", fresh_gnts.size() > idx ? fresh_gnts[idx] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("t5_wrap_second", fresh_gnts.size() > idx + 1 ? fresh_gnts[idx + 1] : 32'hDEAD_BEEF, 32'h0);

        n = 0;
        while (!pending && n < BOUND) begin step(); n++; end
        check("t6_wait", 32'(n < BOUND), 32'd1);
        #2;
        do_reset();
        n = 0;
        while (fresh_gnts.size() == 0 && n < BOUND) begin step(); n++; end
        check("t6_first_addr", fresh_gnts.size() > 0 ? fresh_gnts[0] : 32'hDEAD_BEEF, RESET_PC);

        p_ready = 70;
        p_gnt   = 60;
        max_dly = 3;
        p_redir = 30;
        repeat (3000) step();
        p_redir = 0;
        p_ready = 100;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
